// File: rtl/game_controller.sv
// N-player timed game controller: countdown, saturating scores,
// pause/resume, restart from FINISH and a registered winner/tie result.
module game_controller #(
  parameter int GAME_SECONDS = 30,
  parameter int TIMER_WIDTH  = 6,
  parameter int SCORE_WIDTH  = 6,
  parameter int NUM_PLAYERS  = 2,
  localparam int WIN_W =
    (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clkIn,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   startGame,
  input  logic                   pauseToggle,
  input  logic [NUM_PLAYERS-1:0] player_scored,
  output logic                   game_active,
  output logic                   game_paused,
  output logic                   game_over,
  output logic [TIMER_WIDTH-1:0] time_left,
  output logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores,
  output logic [WIN_W-1:0]       winner,
  output logic                   tie
);

  // One-hot status bits double as the state code, so the
  // status outputs come straight off flops.
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    RUNNING = 3'b001,
    PAUSED  = 3'b010,
    FINISH  = 3'b100
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] T_INIT =
    TIMER_WIDTH'(GAME_SECONDS);
  localparam logic [TIMER_WIDTH-1:0] T_ONE =
    TIMER_WIDTH'(1);
  localparam logic [SCORE_WIDTH-1:0] S_MAX = '1;
  localparam logic [SCORE_WIDTH-1:0] S_ONE =
    SCORE_WIDTH'(1);

  state_t                 r_state;
  logic [TIMER_WIDTH-1:0] r_time;
  logic [SCORE_WIDTH-1:0] r_sc [NUM_PLAYERS];
  logic [WIN_W-1:0]       r_win;
  logic                   r_tie;

  logic [SCORE_WIDTH-1:0] w_sc_run [NUM_PLAYERS];
  logic [SCORE_WIDTH-1:0] w_max;
  logic [WIN_W-1:0]       w_win;
  logic                   w_tie;
  logic                   w_expire;

  assign w_expire = tick && (r_time == T_ONE);

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_sc_run[i] = r_sc[i];
      if (player_scored[i] && (r_sc[i] != S_MAX))
        w_sc_run[i] = r_sc[i] + S_ONE;
    end
  end

  // Result is taken from the scores as they will be after
  // this edge, so an expiry-cycle score is included.
  always_comb begin
    w_max = w_sc_run[0];
    w_win = '0;
    w_tie = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (w_sc_run[i] > w_max) begin
        w_max = w_sc_run[i];
        w_win = WIN_W'(i);
        w_tie = 1'b0;
      end else if (w_sc_run[i] == w_max) begin
        w_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_time  <= T_INIT;
      r_win   <= '0;
      r_tie   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++)
        r_sc[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_time <= T_INIT;
          for (int i = 0; i < NUM_PLAYERS; i++)
            r_sc[i] <= '0;
          r_state <= startGame ? RUNNING : IDLE;
        end
        RUNNING: begin
          for (int i = 0; i < NUM_PLAYERS; i++)
            r_sc[i] <= w_sc_run[i];
          if (w_expire) begin
            r_time  <= '0;
            r_state <= FINISH;
            r_win   <= w_win;
            r_tie   <= w_tie;
          end else begin
            if (tick)
              r_time <= r_time - T_ONE;
            r_state <= pauseToggle ? PAUSED : RUNNING;
          end
        end
        PAUSED: begin
          r_state <= pauseToggle ? RUNNING : PAUSED;
        end
        FINISH: begin
          if (startGame) begin
            r_time <= T_INIT;
            for (int i = 0; i < NUM_PLAYERS; i++)
              r_sc[i] <= '0;
            r_state <= RUNNING;
          end else begin
            r_state <= FINISH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign game_active = r_state[0];
  assign game_paused = r_state[1];
  assign game_over   = r_state[2];
  assign time_left   = r_time;
  assign winner      = r_win;
  assign tie         = r_tie;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign scores[g*SCORE_WIDTH +: SCORE_WIDTH] = r_sc[g];
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: reset, countdown, pause,
// saturation, expiry collisions, restart and winner/tie result.
module tb_game_controller;

  logic        clkIn = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        startGame = 1'b0;
  logic        pauseToggle = 1'b0;
  logic [1:0]  player_scored = 2'b00;

  logic        act, pau, ovr, tie;
  logic [5:0]  tl;
  logic [11:0] sc;
  logic        win;

  logic        s_act, s_pau, s_ovr, s_tie;
  logic [5:0]  s_tl;
  logic [5:0]  s_sc;
  logic        s_win;

  int n_vec = 0;
  int n_err = 0;

  always #5 clkIn = ~clkIn;

  game_controller dut (
    .clkIn(clkIn), .reset(reset), .tick(tick),
    .startGame(startGame), .pauseToggle(pauseToggle),
    .player_scored(player_scored),
    .game_active(act), .game_paused(pau),
    .game_over(ovr), .time_left(tl), .scores(sc),
    .winner(win), .tie(tie)
  );

  game_controller #(.SCORE_WIDTH(3)) dut_sat (
    .clkIn(clkIn), .reset(reset), .tick(tick),
    .startGame(startGame), .pauseToggle(pauseToggle),
    .player_scored(player_scored),
    .game_active(s_act), .game_paused(s_pau),
    .game_over(s_ovr), .time_left(s_tl), .scores(s_sc),
    .winner(s_win), .tie(s_tie)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk_st(input string tag,
                        input logic a, input logic p,
                        input logic o);
    chk({tag, ".active"}, 32'(act), 32'(a));
    chk({tag, ".paused"}, 32'(pau), 32'(p));
    chk({tag, ".over"},   32'(ovr), 32'(o));
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b1;
    chk_st("rst", 0, 0, 0);
    chk("rst.time", 32'(tl), 30);
    chk("rst.scores", 32'(sc), 0);
    chk("rst.winner", 32'(win), 0);
    chk("rst.tie", 32'(tie), 0);

    // mid-game asynchronous reset with time 17, scores {3,5}
    startGame = 1'b1; cyc(); startGame = 1'b0;
    chk_st("start1", 1, 0, 0);
    player_scored = 2'b11; repeat (3) cyc();
    player_scored = 2'b10; repeat (2) cyc();
    player_scored = 2'b00;
    tick = 1'b1; repeat (13) cyc(); tick = 1'b0;
    chk("mid.time", 32'(tl), 17);
    chk("mid.scores", 32'(sc), (5 << 6) | 3);
    #2 reset = 1'b0;
    #1;
    chk_st("arst", 0, 0, 0);
    chk("arst.time", 32'(tl), 30);
    chk("arst.scores", 32'(sc), 0);
    #1 reset = 1'b1;
    cyc();
    chk_st("idle", 0, 0, 0);
    tick = 1'b1; player_scored = 2'b11; cyc();
    tick = 1'b0; player_scored = 2'b00;
    chk("idle.ign.time", 32'(tl), 30);
    chk("idle.ign.scores", 32'(sc), 0);

    // full game: p0 scores 4, p1 scores 2
    startGame = 1'b1; cyc(); startGame = 1'b0;
    chk_st("start2", 1, 0, 0);
    chk("start2.time", 32'(tl), 30);
    for (int k = 0; k < 30; k++) begin
      tick = 1'b1;
      player_scored = {k < 2 ? 1'b1 : 1'b0,
                       k < 4 ? 1'b1 : 1'b0};
      cyc();
      chk("run.time", 32'(tl), 32'(29 - k));
      if (k < 29) chk("run.active", 32'(act), 1);
    end
    tick = 1'b0; player_scored = 2'b00;
    chk_st("fin1", 0, 0, 1);
    chk("fin1.scores", 32'(sc), (2 << 6) | 4);
    chk("fin1.winner", 32'(win), 0);
    chk("fin1.tie", 32'(tie), 0);

    // restart, pause at 20 with a same-cycle score
    startGame = 1'b1; cyc(); startGame = 1'b0;
    chk_st("restart", 1, 0, 0);
    chk("restart.time", 32'(tl), 30);
    chk("restart.scores", 32'(sc), 0);
    chk("restart.winner", 32'(win), 0);
    tick = 1'b1; repeat (10) cyc(); tick = 1'b0;
    chk("pre.pause.time", 32'(tl), 20);
    pauseToggle = 1'b1; player_scored = 2'b01; cyc();
    pauseToggle = 1'b0; player_scored = 2'b00;
    chk_st("pause", 0, 1, 0);
    chk("pause.scores", 32'(sc), 1);
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      player_scored = (k < 3) ? 2'b11 : 2'b00;
      cyc();
    end
    tick = 1'b0; player_scored = 2'b00;
    chk("paused.time", 32'(tl), 20);
    chk("paused.scores", 32'(sc), 1);
    startGame = 1'b1; cyc(); startGame = 1'b0;
    chk_st("paused.start", 0, 1, 0);
    pauseToggle = 1'b1; cyc(); pauseToggle = 1'b0;
    chk_st("resume", 1, 0, 0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("resume.time", 32'(tl), 19);
    startGame = 1'b1; cyc(); startGame = 1'b0;
    chk_st("run.start", 1, 0, 0);
    chk("run.start.time", 32'(tl), 19);

    // expiry with score and pause in the same cycle
    player_scored = 2'b11; repeat (4) cyc();
    player_scored = 2'b00;
    chk("pre.exp.scores", 32'(sc), (4 << 6) | 5);
    tick = 1'b1; repeat (18) cyc(); tick = 1'b0;
    chk("pre.exp.time", 32'(tl), 1);
    tick = 1'b1; player_scored = 2'b10;
    pauseToggle = 1'b1;
    cyc();
    tick = 1'b0; player_scored = 2'b00;
    pauseToggle = 1'b0;
    chk_st("fin2", 0, 0, 1);
    chk("fin2.time", 32'(tl), 0);
    chk("fin2.scores", 32'(sc), (5 << 6) | 5);
    chk("fin2.winner", 32'(win), 0);
    chk("fin2.tie", 32'(tie), 1);
    tick = 1'b1; player_scored = 2'b11;
    pauseToggle = 1'b1;
    cyc();
    tick = 1'b0; player_scored = 2'b00;
    pauseToggle = 1'b0;
    chk_st("fin2.hold", 0, 0, 1);
    chk("fin2.hold.scores", 32'(sc), (5 << 6) | 5);
    startGame = 1'b1; cyc(); startGame = 1'b0;
    chk_st("restart2", 1, 0, 0);
    chk("restart2.time", 32'(tl), 30);
    chk("restart2.scores", 32'(sc), 0);
    chk("restart2.tie", 32'(tie), 1);

    // saturation on the 3-bit instance; p1 wins
    player_scored = 2'b10; repeat (9) cyc();
    player_scored = 2'b00;
    chk("sat.scores", 32'(s_sc), 7 << 3);
    chk("wide.scores", 32'(sc), 9 << 6);
    tick = 1'b1; repeat (30) cyc(); tick = 1'b0;
    chk_st("fin3", 0, 0, 1);
    chk("fin3.winner", 32'(win), 1);
    chk("fin3.tie", 32'(tie), 0);
    chk("sat.over", 32'(s_ovr), 1);
    chk("sat.winner", 32'(s_win), 1);
    chk("sat.scores.fin", 32'(s_sc), 7 << 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Parametrised successor to the single-player game state machine: an N-player game controller with built-in countdown, per-player saturating scores, pause/resume, restart from FINISH, and a registered winner/tie result.
- Sits between the debounced button/scoring logic and the display/seven-segment drivers.
- Runs on the 100 MHz system clock; game timing comes from a single-cycle 1 Hz tick enable rather than a second clock.

Parameters:
- GAME_SECONDS, 30, countdown length in seconds; must be ≥1 and ≤ 2^TIMER_WIDTH-1.
- TIMER_WIDTH, 6, width of time_left.
- SCORE_WIDTH, 6, width of each player's score.
- NUM_PLAYERS, 2, number of players; must be ≥1.
- WIN_W (localparam), max(1, clog2(NUM_PLAYERS)), width of the winner index.

Ports:
- clkIn  input  1  100 MHz system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-clkIn-cycle pulse at 1 Hz.
- startGame  input  1  single-cycle start/restart request.
- pauseToggle  input  1  single-cycle pause/resume request.
- player_scored  input  NUM_PLAYERS  bit i = one-cycle score pulse for player i.
- game_active  output  1  high in RUNNING only.
- game_paused  output  1  high in PAUSED only.
- game_over  output  1  high in FINISH only.
- time_left  output  TIMER_WIDTH  seconds remaining.
- scores  output  NUM_PLAYERS*SCORE_WIDTH  packed; player i occupies bits [i*SCORE_WIDTH +: SCORE_WIDTH].
- winner  output  WIN_W  index of the winning player; valid when game_over is high.
- tie  output  1  high when two or more players share the top score; valid when game_over is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - time_left = GAME_SECONDS.
  - All scores, winner and tie = 0.
  - game_active, game_paused and game_over = 0.
- Status outputs (game_active, game_paused, game_over) are registered and decoded from the current state, with no extra latency: each is high in the same cycle its state is.
- States: IDLE, RUNNING, PAUSED, FINISH.
- IDLE:
  - startGame → RUNNING next cycle.
  - time_left reloads to GAME_SECONDS.
  - Scores cleared.
  - tick, pauseToggle and player_scored are ignored.
- RUNNING:
  - A set player_scored[i] increments score i by 1. All players may score in the same cycle.
  - Scores saturate at 2^SCORE_WIDTH-1 with no wrap.
  - tick decrements time_left by 1.
  - tick while time_left==1 → time_left=0 and state → FINISH.
  - pauseToggle (without expiry) → PAUSED.
  - startGame is ignored.
- Simultaneous events in RUNNING:
  - A score in the expiry cycle counts.
  - Expiry beats pauseToggle: go to FINISH, pause is dropped.
  - A score in the same cycle as pauseToggle counts.
- PAUSED:
  - time_left and scores frozen; tick and player_scored ignored.
  - pauseToggle → RUNNING.
  - startGame is ignored.
- FINISH:
  - Scores and time_left (0) are held.
  - startGame → RUNNING directly: scores cleared and time_left=GAME_SECONDS in that same transition cycle.
  - Other inputs are ignored.
- Result logic (winner, tie):
  - Computed from the final scores and registered on the clock edge that enters FINISH, so it is valid in the first cycle game_over is high. The final scores include any score taken in the expiry cycle.
  - winner = lowest index holding the maximum score.
  - tie = 1 if more than one player holds the maximum.
  - With NUM_PLAYERS=1: winner=0, tie=0.
  - winner and tie hold until the next FINISH entry or reset; they are not cleared on restart.
- Reset asserted mid-game (any state) returns immediately to reset values; there is no partial state.
- Level-held inputs: each cycle a level-held input is high counts as one event. Edge detection is the caller's job.
- The combined next-state logic must be a single always block with non-blocking assignments. No latches: every state must assign its next state on every path.

Test Plan:
- Reset mid-RUNNING with time_left=17 and scores {3,5}: all outputs return to reset values asynchronously, before the next clkIn edge; state IDLE.
- startGame, then 30 ticks with player 0 scoring 4× and player 1 scoring 2×:
  - game_active for 30 ticks; time_left goes 30→0.
  - game_over asserted on the cycle after the 30th tick.
  - scores={4,2}, winner=0, tie=0.
- Pause after 10 ticks, then 5 ticks and 3 player_scored pulses while PAUSED, then pauseToggle:
  - time_left stays 20 and scores unchanged while paused.
  - Resume continues counting from 20.
- Saturation: SCORE_WIDTH=3, 9 score pulses for player 1 → score stays 7.
- Final tick coincides with player_scored[1] and pauseToggle:
  - The score counts and state becomes FINISH, not PAUSED.
  - With equal scores {5,5}: winner=0, tie=1.
- In FINISH, startGame → RUNNING next cycle with scores=0 and time_left=30. startGame while RUNNING or PAUSED has no effect.
